// File: rtl/sata_link_manager.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sata_link_manager : SATA PHY/OOB bring-up sequencer (speed select, lock, retry)
// Revision: 1.0
// ---------------------------------------------------------------------------
module sata_link_manager #(
  parameter int HOLD_CYCLES  = 16,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int LINK_TIMEOUT = 1500000,
  parameter int ATTEMPTS     = 3,
  parameter int LOSS_FILTER  = 8,
  parameter bit START_GEN2   = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       host_reset_req,
  input  logic       rx_locked,
  input  logic       linkup,
  input  logic       speed_ack,
  output logic       oob_reset,
  output logic       gen2,
  output logic       speed_req,
  output logic       link_up,
  output logic       link_lost,
  output logic       speed_fallback,
  output logic [3:0] attempt_cnt,
  output logic [2:0] state_out
);

  typedef enum logic [2:0] {
    RESET_HOLD = 3'd0,
    SPEED_REQ  = 3'd1,
    WAIT_LOCK  = 3'd2,
    OOB_RUN    = 3'd3,
    LINKED     = 3'd4,
    FAIL       = 3'd5
  } state_t;

  localparam int          LOSS_W    = $clog2(LOSS_FILTER + 1);
  localparam logic [23:0] HOLD_LAST = 24'(HOLD_CYCLES - 1);
  localparam logic [23:0] LOCK_LAST = 24'(LOCK_TIMEOUT - 1);
  localparam logic [23:0] LINK_LAST = 24'(LINK_TIMEOUT - 1);
  localparam logic [3:0]  ATT_LAST  = 4'(ATTEMPTS - 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_FILTER - 1);

  state_t            state_q, state_d;
  logic [23:0]       timer_q, timer_d;
  logic [3:0]        attempt_q, attempt_d;
  logic [LOSS_W-1:0] loss_cnt_q, loss_cnt_d;
  logic              gen2_q, gen2_d;
  logic              dirty_q, dirty_d;
  logic              oob_reset_q, oob_reset_d;
  logic              speed_req_q, speed_req_d;
  logic              link_up_q, link_up_d;
  logic              link_lost_q, link_lost_d;
  logic              speed_fallback_q, speed_fallback_d;

  always_comb begin
    state_d          = state_q;
    attempt_d        = attempt_q;
    gen2_d           = gen2_q;
    loss_cnt_d       = '0;
    link_lost_d      = 1'b0;
    speed_fallback_d = 1'b0;

    case (state_q)
      RESET_HOLD: begin
        if (timer_q == HOLD_LAST) state_d = dirty_q ? SPEED_REQ : WAIT_LOCK;
      end
      SPEED_REQ: begin
        if (speed_ack) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (rx_locked)                 state_d = OOB_RUN;
        else if (timer_q == LOCK_LAST) state_d = FAIL;
      end
      OOB_RUN: begin
        if (linkup)                    state_d = LINKED;
        else if (timer_q == LINK_LAST) state_d = FAIL;
      end
      FAIL: begin
        if (attempt_q == ATT_LAST) begin
          attempt_d        = 4'd0;
          gen2_d           = ~gen2_q;
          speed_fallback_d = 1'b1;
        end else begin
          attempt_d = attempt_q + 4'd1;
        end
        state_d = RESET_HOLD;
      end
      LINKED: begin
        if (!linkup) begin
          if (loss_cnt_q == LOSS_LAST) begin
            link_lost_d = 1'b1;
            gen2_d      = START_GEN2;
            attempt_d   = 4'd0;
            state_d     = RESET_HOLD;
          end else begin
            loss_cnt_d = loss_cnt_q + LOSS_W'(1);
          end
        end
      end
      default: state_d = RESET_HOLD;
    endcase

    if (state_d == LINKED && state_q != LINKED) attempt_d = 4'd0;

    // Host restart overrides everything, including pending pulses.
    if (host_reset_req) begin
      state_d          = RESET_HOLD;
      attempt_d        = 4'd0;
      gen2_d           = START_GEN2;
      loss_cnt_d       = '0;
      link_lost_d      = 1'b0;
      speed_fallback_d = 1'b0;
    end

    // A host restart from RESET_HOLD re-enters the state and restarts the hold.
    timer_d = (host_reset_req || state_d != state_q) ? 24'd0 : timer_q + 24'd1;

    if (gen2_d != gen2_q) dirty_d = 1'b1;
    else if (speed_ack)   dirty_d = 1'b0;
    else                  dirty_d = dirty_q;

    oob_reset_d = !(state_d == OOB_RUN || state_d == LINKED);
    speed_req_d = (state_d == SPEED_REQ);
    link_up_d   = (state_d == LINKED);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= RESET_HOLD;
      timer_q          <= 24'd0;
      attempt_q        <= 4'd0;
      loss_cnt_q       <= '0;
      gen2_q           <= START_GEN2;
      dirty_q          <= 1'b1;
      oob_reset_q      <= 1'b1;
      speed_req_q      <= 1'b0;
      link_up_q        <= 1'b0;
      link_lost_q      <= 1'b0;
      speed_fallback_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      timer_q          <= timer_d;
      attempt_q        <= attempt_d;
      loss_cnt_q       <= loss_cnt_d;
      gen2_q           <= gen2_d;
      dirty_q          <= dirty_d;
      oob_reset_q      <= oob_reset_d;
      speed_req_q      <= speed_req_d;
      link_up_q        <= link_up_d;
      link_lost_q      <= link_lost_d;
      speed_fallback_q <= speed_fallback_d;
    end
  end

  assign oob_reset      = oob_reset_q;
  assign gen2           = gen2_q;
  assign speed_req      = speed_req_q;
  assign link_up        = link_up_q;
  assign link_lost      = link_lost_q;
  assign speed_fallback = speed_fallback_q;
  assign attempt_cnt    = attempt_q;
  assign state_out      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_sata_link_manager.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sata_link_manager : scenario bench for the SATA link bring-up sequencer
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_sata_link_manager;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       host_reset_req = 1'b0;
  logic       rx_locked = 1'b0;
  logic       linkup = 1'b0;
  logic       speed_ack = 1'b0;
  logic       oob_reset, gen2, speed_req, link_up, link_lost, speed_fallback;
  logic [3:0] attempt_cnt;
  logic [2:0] state_out;

  int total = 0;
  int bad   = 0;

  // Expected post-FAIL results {fallback, gen2, attempt[3:0]} and misc values.
  logic [5:0] sb_q[$];
  logic [5:0] exp_v;

  // Statistics collected while waiting for a state.
  bit   auto_ack = 1'b0;
  int   n_in2, n_in3;
  bit   req_seen, oob_low, lost_seen;
  logic req_gen2;

  sata_link_manager #(
    .HOLD_CYCLES (16),
    .LOCK_TIMEOUT(50),
    .LINK_TIMEOUT(200),
    .ATTEMPTS    (3),
    .LOSS_FILTER (8),
    .START_GEN2  (1'b1)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .host_reset_req(host_reset_req),
    .rx_locked     (rx_locked),
    .linkup        (linkup),
    .speed_ack     (speed_ack),
    .oob_reset     (oob_reset),
    .gen2          (gen2),
    .speed_req     (speed_req),
    .link_up       (link_up),
    .link_lost     (link_lost),
    .speed_fallback(speed_fallback),
    .attempt_cnt   (attempt_cnt),
    .state_out     (state_out)
  );

  always #5 clk = ~clk;

  // Steps negedge by negedge until state_out==target; optionally answers speed_req.
  task automatic wait_state(input logic [2:0] target, input int budget, output bit ok);
    ok = 1'b0;
    n_in2 = 0; n_in3 = 0; req_seen = 1'b0; oob_low = 1'b0; req_gen2 = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (state_out == target) begin
        ok = 1'b1;
        speed_ack = 1'b0;
        break;
      end
      if (state_out == 3'd2) n_in2++;
      if (state_out == 3'd3) n_in3++;
      if (oob_reset == 1'b0) oob_low = 1'b1;
      if (state_out == 3'd1) begin
        req_seen = 1'b1;
        req_gen2 = gen2;
      end
      speed_ack = (auto_ack && state_out == 3'd1);
      @(negedge clk);
    end
    speed_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (state_out !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d expected 0", state_out); end
    total++; if (oob_reset !== 1'b1) begin bad++; $display("FAIL reset_oob: got %b expected 1", oob_reset); end
    total++; if (gen2 !== 1'b1) begin bad++; $display("FAIL reset_gen2: got %b expected 1", gen2); end
    total++; if ({speed_req, link_up, link_lost, speed_fallback} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags: got %b expected 0000", {speed_req, link_up, link_lost, speed_fallback});
    end
    total++; if (attempt_cnt !== 4'd0) begin bad++; $display("FAIL reset_attempt: got %0d expected 0", attempt_cnt); end
  endtask

  task automatic test_bringup();
    int  cnt;
    bit  hold_oob_low;
    bit  ok;
    rx_locked = 1'b1;
    reset_n   = 1'b1;
    cnt = 0; hold_oob_low = 1'b0;
    while (state_out == 3'd0 && cnt < 100) begin
      if (oob_reset !== 1'b1) hold_oob_low = 1'b1;
      cnt++;
      @(negedge clk);
    end
    total++; if (cnt != 16) begin bad++; $display("FAIL hold_len: got %0d expected 16", cnt); end
    total++; if (hold_oob_low) begin bad++; $display("FAIL hold_oob: got 0 expected 1"); end
    sb_q.push_back(6'b01_0000);
    exp_v = sb_q.pop_front();
    total++; if ({state_out, speed_req, gen2} !== {3'd1, 1'b1, exp_v[4]}) begin
      bad++; $display("FAIL speed_req_entry: got st=%0d req=%b gen2=%b expected st=1 req=1 gen2=%b",
                      state_out, speed_req, gen2, exp_v[4]);
    end
    repeat (3) @(negedge clk);
    total++; if (speed_req !== 1'b1) begin bad++; $display("FAIL speed_req_held: got %b expected 1", speed_req); end
    speed_ack = 1'b1;
    @(negedge clk);
    speed_ack = 1'b0;
    total++; if ({state_out, speed_req} !== {3'd2, 1'b0}) begin
      bad++; $display("FAIL speed_ack_exit: got st=%0d req=%b expected st=2 req=0", state_out, speed_req);
    end
    wait_state(3'd3, 20, ok);
    total++; if (!ok || oob_reset !== 1'b0) begin
      bad++; $display("FAIL oob_run_entry: got ok=%b oob=%b expected ok=1 oob=0", ok, oob_reset);
    end
    repeat (99) @(negedge clk);
    linkup = 1'b1;
    @(negedge clk);
    total++; if ({state_out, link_up, attempt_cnt} !== {3'd4, 1'b1, 4'd0}) begin
      bad++; $display("FAIL linked_entry: got st=%0d up=%b att=%0d expected st=4 up=1 att=0",
                      state_out, link_up, attempt_cnt);
    end
  endtask

  task automatic test_retry_fallback();
    logic [3:0] att_m;
    logic       gen_m, fb_m, prev_fb, gen_before;
    bit         ok;
    att_m = 4'd0; gen_m = 1'b1; prev_fb = 1'b0;
    host_reset_req = 1'b1;
    linkup = 1'b0;
    @(negedge clk);
    host_reset_req = 1'b0;
    auto_ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      gen_before = gen_m;
      fb_m  = (att_m == 4'd2);
      att_m = fb_m ? 4'd0 : att_m + 4'd1;
      gen_m = fb_m ? ~gen_m : gen_m;
      sb_q.push_back({fb_m, gen_m, att_m});
      wait_state(3'd5, 2000, ok);
      total++; if (!ok) begin bad++; $display("FAIL fail_reach_%0d: got timeout expected FAIL state", i); end
      if (i == 0) begin
        total++; if (n_in3 != 200) begin bad++; $display("FAIL link_timeout_len: got %0d expected 200", n_in3); end
      end
      total++; if (req_seen !== prev_fb || (prev_fb && req_gen2 !== gen_before)) begin
        bad++; $display("FAIL req_handshake_%0d: got seen=%b gen2=%b expected seen=%b gen2=%b",
                        i, req_seen, req_gen2, prev_fb, gen_before);
      end
      @(negedge clk);
      exp_v = sb_q.pop_front();
      total++; if ({state_out, speed_fallback, gen2, attempt_cnt} !== {3'd0, exp_v}) begin
        bad++; $display("FAIL after_fail_%0d: got st=%0d fb=%b gen2=%b att=%0d expected st=0 fb=%b gen2=%b att=%0d",
                        i, state_out, speed_fallback, gen2, attempt_cnt, exp_v[5], exp_v[4], exp_v[3:0]);
      end
      @(negedge clk);
      total++; if (speed_fallback !== 1'b0) begin bad++; $display("FAIL fallback_width_%0d: got 1 expected 0", i); end
      prev_fb = fb_m;
    end
  endtask

  task automatic test_link_loss();
    bit ok;
    wait_state(3'd3, 500, ok);
    linkup = 1'b1;
    @(negedge clk);
    total++; if (!ok || state_out !== 3'd4) begin bad++; $display("FAIL relink: got st=%0d expected 4", state_out); end
    linkup = 1'b0;
    lost_seen = 1'b0;
    repeat (7) begin
      @(negedge clk);
      if (link_lost) lost_seen = 1'b1;
    end
    linkup = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (link_lost) lost_seen = 1'b1;
    end
    total++; if (lost_seen || state_out !== 3'd4) begin
      bad++; $display("FAIL loss_filter_7: got st=%0d lost=%b expected st=4 lost=0", state_out, lost_seen);
    end
    linkup = 1'b0;
    lost_seen = 1'b0;
    repeat (7) begin
      @(negedge clk);
      if (state_out != 3'd4) lost_seen = 1'b1;
    end
    total++; if (lost_seen) begin bad++; $display("FAIL loss_early: got early exit expected 7 cycles in LINKED"); end
    @(negedge clk);
    total++; if ({state_out, link_lost, link_up, gen2} !== {3'd0, 1'b1, 1'b0, 1'b1}) begin
      bad++; $display("FAIL loss_8: got st=%0d lost=%b up=%b gen2=%b expected st=0 lost=1 up=0 gen2=1",
                      state_out, link_lost, link_up, gen2);
    end
    @(negedge clk);
    total++; if (link_lost !== 1'b0) begin bad++; $display("FAIL lost_width: got 1 expected 0"); end
  endtask

  task automatic test_lock_timeout();
    int cnt;
    bit ok, low;
    rx_locked = 1'b0;
    wait_state(3'd2, 100, ok);
    cnt = 0; low = 1'b0;
    while (state_out == 3'd2 && cnt < 200) begin
      if (oob_reset !== 1'b1) low = 1'b1;
      cnt++;
      @(negedge clk);
    end
    total++; if (!ok || cnt != 50 || state_out !== 3'd5) begin
      bad++; $display("FAIL lock_timeout: got cycles=%0d st=%0d expected cycles=50 st=5", cnt, state_out);
    end
    total++; if (low || oob_reset !== 1'b1) begin bad++; $display("FAIL lock_oob: got deasserted expected held"); end
    sb_q.push_back(6'b01_0001);
    @(negedge clk);
    exp_v = sb_q.pop_front();
    total++; if ({gen2, attempt_cnt} !== exp_v[4:0]) begin
      bad++; $display("FAIL lock_attempt: got gen2=%b att=%0d expected gen2=%b att=%0d",
                      gen2, attempt_cnt, exp_v[4], exp_v[3:0]);
    end
  endtask

  task automatic test_host_reset();
    bit ok;
    auto_ack = 1'b0;
    wait_state(3'd1, 500, ok);
    total++; if (!ok || gen2 !== 1'b0 || attempt_cnt !== 4'd0) begin
      bad++; $display("FAIL gen1_req: got ok=%b gen2=%b att=%0d expected ok=1 gen2=0 att=0", ok, gen2, attempt_cnt);
    end
    host_reset_req = 1'b1;
    @(negedge clk);
    host_reset_req = 1'b0;
    total++; if ({state_out, speed_req, gen2, attempt_cnt} !== {3'd0, 1'b0, 1'b1, 4'd0}) begin
      bad++; $display("FAIL host_reset: got st=%0d req=%b gen2=%b att=%0d expected st=0 req=0 gen2=1 att=0",
                      state_out, speed_req, gen2, attempt_cnt);
    end
  endtask

  task automatic test_timeout_boundary();
    bit ok, left;
    rx_locked = 1'b1;
    auto_ack  = 1'b1;
    wait_state(3'd3, 500, ok);
    total++; if (!ok || req_seen !== 1'b1) begin
      bad++; $display("FAIL regen2_req: got ok=%b seen=%b expected ok=1 seen=1", ok, req_seen);
    end
    left = 1'b0;
    repeat (199) begin
      @(negedge clk);
      if (state_out != 3'd3) left = 1'b1;
    end
    linkup = 1'b1;
    @(negedge clk);
    total++; if (left || {state_out, link_up} !== {3'd4, 1'b1}) begin
      bad++; $display("FAIL linkup_at_timeout: got st=%0d up=%b left=%b expected st=4 up=1 left=0",
                      state_out, link_up, left);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    total++; if ({state_out, oob_reset, link_up} !== {3'd0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL async_reset: got st=%0d oob=%b up=%b expected st=0 oob=1 up=0",
                      state_out, oob_reset, link_up);
    end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_retry_fallback();
    test_link_loss();
    test_lock_timeout();
    test_host_reset();
    test_timeout_boundary();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
